// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM encoding and
// the parameter legality check used at elaboration.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit chunk_cfg_ok(int width, int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/seq_chunk_adder_rca_slice.sv
// CHUNK-bit combinational ripple-carry slice built from full adders.
module rca_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice is reused
// NCHUNK times, carry held in a register between chunks.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// RUN   | one chunk per clock through the slice
// DONE  | result presented, out_valid=1 until out_ready
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH");
    end

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_sr, b_sr, sum_sr, sum_nxt;
    logic              carry;
    logic [CW-1:0]     count;
    logic [CHUNK-1:0]  slice_s;
    logic              slice_co;
    logic              load, step, last;

    rca_slice #(.CHUNK(CHUNK)) u_slice (
        .a  (a_sr[CHUNK-1:0]),
        .b  (b_sr[CHUNK-1:0]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // New chunk enters at the top so the last one lands in the MSBs.
    always_comb begin
        sum_nxt = sum_sr >> CHUNK;
        sum_nxt[WIDTH-1 -: CHUNK] = slice_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            Sum    <= '0;
            Cout   <= 1'b0;
            Ovf    <= 1'b0;
        end else if (load) begin
            a_sr  <= A;
            b_sr  <= sub ? ~B : B;
            carry <= sub ? ~Cin : Cin;
            count <= '0;
        end else if (step) begin
            a_sr   <= a_sr >> CHUNK;
            b_sr   <= b_sr >> CHUNK;
            sum_sr <= sum_nxt;
            carry  <= slice_co;
            count  <= count + CW'(1);
            // On the final chunk the low slice bits hold the operand MSBs.
            if (last) begin
                Sum  <= sum_nxt;
                Cout <= slice_co;
                Ovf  <= (a_sr[CHUNK-1] == b_sr[CHUNK-1]) &&
                        (slice_s[CHUNK-1] != a_sr[CHUNK-1]);
            end
        end
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the 4-bit combinational ripple-carry adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock through one CHUNK-bit ripple-carry slice, with the carry held in a register between chunks.
- Valid/ready handshakes on both sides, so it drops into datapaths that trade latency for area.
- Adds a subtract mode and signed-overflow detection, which the 4-bit adder does not have.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; must be at least 1 and at most WIDTH.
- NCHUNK, WIDTH/CHUNK, derived localparam: cycles per operation.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept a new operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = A+B+Cin, 1 = A-B-Cin.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- Sum  output  WIDTH  result.
- Cout  output  1  carry-out; in sub mode 1 = no borrow.
- Ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, Sum=0, Cout=0, Ovf=0, internal operand/carry/count registers=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready at an edge, latch A and B' and go to RUN, with count=0. B'=sub?~B:B. Carry register=sub?~Cin:Cin.
  - RUN: in_ready=0, out_valid=0. At each edge, add chunk[count] of A and B' plus the carry register in the CHUNK-bit slice. Store the chunk sum and update the carry register. Then count++.
  - On the edge that processes chunk NCHUNK-1: load Sum, Cout=final carry and Ovf, then go to DONE.
  - DONE: out_valid=1, in_ready=0. Sum, Cout and Ovf stay stable. On out_valid&out_ready at an edge, go to IDLE and deassert out_valid.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge. Throughput is one operation per NCHUNK+2 cycles at best.
- A new accept requires a return to IDLE; no overlap.
- Ovf = (A[MSB]==B'[MSB]) && (Sum[MSB]!=A[MSB]).
- All arithmetic is modulo 2^WIDTH; Cout is bit WIDTH of the full sum.
- Inputs A, B, Cin and sub are sampled only on the accept edge. Changes during RUN or DONE are ignored.
- in_valid while busy: not accepted, no effect. The upstream side must hold it.
- out_ready while not DONE: ignored.
- Sum, Cout and Ovf keep the last result after the DONE→IDLE transition, until the next completion or reset.
- Reset mid-RUN or mid-DONE: immediate return to reset values. The in-flight operation is discarded and no out_valid pulse occurs.
- NCHUNK=1 (CHUNK=WIDTH): RUN lasts one cycle; behaves as a registered single-cycle adder.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The WIDTH%CHUNK==0 elaboration check.
- One sub-module: rca_slice (CHUNK-parameterised combinational ripple-carry slice built from full adders; inputs a, b, ci; outputs s, co).
- The top level holds the FSM, operand shift registers and counter.

Test Plan:
- WIDTH=4, CHUNK=4: A=4'b1010, B=4'b1001, Cin=0, sub=0 → out_valid 1 cycle after accept; Sum=4'b0011, Cout=1, Ovf=1.
- WIDTH=16, CHUNK=4: A=0x1234, B=0x0FFF, Cin=0, add → out_valid exactly 4 cycles after accept; Sum=0x2233, Cout=0, Ovf=0.
- Carry ripple across chunks and overflow:
  - A=0xFFFF, B=0x0001 → Sum=0x0000, Cout=1, Ovf=0.
  - A=0x7FFF, B=0x0001 → Sum=0x8000, Cout=0, Ovf=1.
- Subtract mode:
  - A=0x0005, B=0x0007, Cin=0, sub=1 → Sum=0xFFFE, Cout=0, Ovf=0.
  - A=0x0007, B=0x0005, Cin=1, sub=1 → Sum=0x0001, Cout=1.
- Backpressure and busy rejection:
  - Hold out_ready=0 for 5 cycles in DONE → Sum, Cout and out_valid stay stable. Release → in_ready=1 the next cycle.
  - in_valid pulsed during RUN with other operands → ignored; first result unchanged.
- Reset during RUN: deassert rst_n after 2 of 4 chunks → outputs go to reset values immediately, with no out_valid. A fresh op after reset computes correctly.
